// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared SoC constants for the memory arbiter
package mem_arbiter_pkg;

   localparam int PORT_I            = 0;
   localparam int PORT_D            = 1;
   localparam int MEM_WORDS_DEFAULT = 256;

   // Byte address is valid when it falls below words*4; widened so huge sizes cannot overflow
   function automatic logic addr_in_range(input logic [31:0] addr, input int words);
      return ({2'b00, addr} < ({2'b00, 32'(words)} << 2));
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-requester round-robin arbiter with registered last-grant pointer
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // 1 when the D port holds the most recent grant; reset to I so D wins the first tie
   logic last_d_q;

   // Grant the lone requester, or on a tie the port that was not served last
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req[PORT_I] && req[PORT_D]) begin
            if (last_d_q) gnt[PORT_I] = 1'b1;
            else          gnt[PORT_D] = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   // Remember who was granted so the next tie goes the other way
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_q <= 1'b0;
      end else if (gnt[PORT_D]) begin
         last_d_q <= 1'b1;
      end else if (gnt[PORT_I]) begin
         last_d_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates an instruction port and a data port onto one synchronous memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic        d_gnt,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   output logic [31:0] cnt_i,
   output logic [31:0] cnt_d
);

   logic [1:0]  gnt;
   logic [31:0] sel_addr;
   logic        sel_in_range;
   logic        sel_is_write;
   logic        any_gnt;
   logic        pend_i_q;
   logic        pend_d_q;
   logic        pend_oor_q;
   logic [31:0] cnt_i_q;
   logic [31:0] cnt_d_q;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({d_req, i_req}),
      .gnt (gnt)
   );

   assign i_gnt   = gnt[PORT_I];
   assign d_gnt   = gnt[PORT_D];
   assign any_gnt = i_gnt | d_gnt;

   // Steer the granted port onto the memory; out-of-range accesses never touch it
   always_comb begin
      sel_addr     = d_gnt ? d_addr : i_addr;
      sel_in_range = addr_in_range(sel_addr, MEM_WORDS);
      sel_is_write = d_gnt && (d_wmask != 4'b0000);
      mem_addr     = sel_addr;
      mem_wdata    = d_wdata;
      mem_ren      = any_gnt && sel_in_range && !sel_is_write;
      mem_wmask    = (sel_is_write && sel_in_range) ? d_wmask : 4'b0000;
   end

   // Track which port owns the response due next cycle and whether it was out of range
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_i_q   <= 1'b0;
         pend_d_q   <= 1'b0;
         pend_oor_q <= 1'b0;
      end else begin
         pend_i_q   <= i_gnt;
         pend_d_q   <= d_gnt && (!sel_is_write || !sel_in_range);
         pend_oor_q <= any_gnt && !sel_in_range;
      end
   end

   // Per-port grant counters, free-running with natural wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_i_q <= 32'd0;
         cnt_d_q <= 32'd0;
      end else begin
         if (i_gnt) cnt_i_q <= cnt_i_q + 32'd1;
         if (d_gnt) cnt_d_q <= cnt_d_q + 32'd1;
      end
   end

   // Responses are masked during reset so a read caught by reset never surfaces
   always_comb begin
      i_rvalid = pend_i_q && !rst;
      d_rvalid = pend_d_q && !rst;
      i_rdata  = (i_rvalid && !pend_oor_q) ? mem_rdata : 32'd0;
      d_rdata  = (d_rvalid && !pend_oor_q) ? mem_rdata : 32'd0;
      d_err    = d_rvalid && pend_oor_q;
   end

   assign cnt_i = cnt_i_q;
   assign cnt_d = cnt_d_q;

endmodule
